i2si_sample_fifo: RTL
=====================

// Module: i2si_sample_fifo
// PURPOSE
// Stereo sample buffer directly downstream of i2si_deserializer. Captures each
// {i2si_lft, i2si_rgt} pair on the deserializer's i2si_xfc strobe into a DEPTH-entry
// FIFO and presents the oldest pair to the register-file/bus side with a pop handshake.
// Also reports fill level, almost-full interrupt and sticky overflow.
// PARAMETERS
// DATA_W     16  width of each channel sample
// DEPTH      8   FIFO entries (stereo pairs); power of 2, >= 2
// AF_THRESH  6   level at or above which i2si_irq asserts; 1..DEPTH
// PORTS
// clk             in   1             system clock, all logic rising-edge
// rst             in   1             asynchronous, active-low reset
// rf_i2si_en      in   1             block enable; low = flush and hold empty
// i2si_lft        in   DATA_W        left sample from deserializer
// i2si_rgt        in   DATA_W        right sample from deserializer
// i2si_xfc        in   1             1-cycle push strobe from deserializer
// rf_i2si_rd      in   1             pop strobe; one pair consumed per cycle high
// rf_i2si_ovf_clr in   1             clears sticky overflow flag
// rf_i2si_lft     out  DATA_W        head-of-FIFO left sample
// rf_i2si_rgt     out  DATA_W        head-of-FIFO right sample
// rf_i2si_vld     out  1             head data valid (= not empty)
// rf_i2si_full    out  1             FIFO holds DEPTH pairs
// rf_i2si_lvl     out  $clog2(DEPTH)+1  current number of stored pairs
// rf_i2si_ovf     out  1             sticky: a push was dropped
// i2si_irq        out  1             level >= AF_THRESH (registered)
// BEHAVIOUR
// - Reset (rst=0, async): wr/rd pointers, lvl=0, vld=0, full=0, ovf=0, irq=0;
//   rf_i2si_lft/rgt=0. Memory array not reset. Reset mid-stream discards all data.
// - Storage: DEPTH x 2*DATA_W register array; pointers $clog2(DEPTH)+1 bits, MSB
//   wraps; empty = ptrs equal, full = low bits equal and MSB differ.
// - Push: i2si_xfc=1 & rf_i2si_en=1 & (!full | pop this cycle) -> write pair at
//   wr_ptr, wr_ptr+1. Data visible / vld high the cycle after the push edge.
// - Pop: rf_i2si_rd=1 & vld=1 -> rd_ptr+1; next head visible following cycle.
//   Pop while empty ignored, no flag, pointers unchanged.
// - Show-ahead: rf_i2si_lft/rgt always reflect entry at rd_ptr when vld=1; hold
//   last value (no X) when empty.
// - Simultaneous push+pop: both occur, lvl unchanged; allowed when full (no ovf)
//   and when empty (pop ignored, push accepted, lvl 0->1).
// - Overflow: push while full without pop -> new pair dropped, contents intact,
//   rf_i2si_ovf=1 next cycle. Stays set until rf_i2si_ovf_clr=1; set wins over clr
//   in the same cycle.
// - lvl: wr_ptr - rd_ptr, range 0..DEPTH, updated same edge as pointers.
// - i2si_irq: registered compare lvl_next >= AF_THRESH; level, not pulse.
// - rf_i2si_en=0: next edge resets pointers (lvl=0, vld=0, irq=0), pushes and
//   pops ignored while low; ovf cleared. Re-enable starts empty.
// - No combinational path from any input to any output except none; all outputs
//   registered or decoded from registered pointers/array.
// TESTING
// 1 Reset: assert rst=0 mid-fill (lvl=3) -> all outputs 0 immediately, lvl=0 after.
// 2 Push 0xAAAA/0xFF00 then 0x1478/0xA3B9 -> vld=1, head 0xAAAA/0xFF00, lvl=2;
//   pop -> head 0x1478/0xA3B9, lvl=1; pop -> vld=0, lvl=0.
// 3 DEPTH=8: push 8 pairs -> full=1, irq=1 from lvl=6; 9th push -> ovf=1, head
//   still pair 1; ovf_clr -> ovf=0; pop 8 -> pairs 1..8 in order, no 9th.
// 4 Full + push + pop same cycle -> lvl stays 8, ovf=0, newest pair at tail.
// 5 Empty + push + pop same cycle -> lvl=1, pushed pair at head; pop on empty -> no change.
// 6 rf_i2si_en=0 with lvl=5 -> lvl=0, vld=0 next cycle; xfc while low ignored.

Source files
------------

// File: rtl/i2si_sample_fifo.sv
// Stereo sample FIFO between the I2S deserializer and the register file.
// Show-ahead head register, fill level, almost-full interrupt and sticky overflow.
module i2si_sample_fifo #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rf_i2si_en,
   input  logic [DATA_W-1:0]        i2si_lft,
   input  logic [DATA_W-1:0]        i2si_rgt,
   input  logic                     i2si_xfc,
   input  logic                     rf_i2si_rd,
   input  logic                     rf_i2si_ovf_clr,
   output logic [DATA_W-1:0]        rf_i2si_lft,
   output logic [DATA_W-1:0]        rf_i2si_rgt,
   output logic                     rf_i2si_vld,
   output logic                     rf_i2si_full,
   output logic [$clog2(DEPTH):0]   rf_i2si_lvl,
   output logic                     rf_i2si_ovf,
   output logic                     i2si_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

   logic [2*DATA_W-1:0] mem [DEPTH];
   logic [2*DATA_W-1:0] head;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr_next;
   logic [PW-1:0]       rd_ptr_next;
   logic [PW-1:0]       lvl_next;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic                ovf_set;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   always_comb begin
      pop         = rf_i2si_en && rf_i2si_rd && !empty;
      push        = rf_i2si_en && i2si_xfc && (!full || pop);
      ovf_set     = rf_i2si_en && i2si_xfc && full && !pop;
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (!rf_i2si_en) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr + PW'(1);
         if (pop)  rd_ptr_next = rd_ptr + PW'(1);
      end
      lvl_next = wr_ptr_next - rd_ptr_next;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {i2si_lft, i2si_rgt};
   end

   // The head register follows the next read slot; when that slot is being written this
   // edge the incoming pair is forwarded. It holds its last value while empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         head        <= '0;
         rf_i2si_ovf <= 1'b0;
         i2si_irq    <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_next;
         rd_ptr   <= rd_ptr_next;
         i2si_irq <= rf_i2si_en && (lvl_next >= AF_LVL);
         if (wr_ptr_next != rd_ptr_next) begin
            if (push && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0]))
               head <= {i2si_lft, i2si_rgt};
            else
               head <= mem[rd_ptr_next[AW-1:0]];
         end
         if (!rf_i2si_en)
            rf_i2si_ovf <= 1'b0;
         else if (ovf_set)
            rf_i2si_ovf <= 1'b1;
         else if (rf_i2si_ovf_clr)
            rf_i2si_ovf <= 1'b0;
      end
   end

   assign rf_i2si_lft  = head[2*DATA_W-1:DATA_W];
   assign rf_i2si_rgt  = head[DATA_W-1:0];
   assign rf_i2si_vld  = !empty;
   assign rf_i2si_full = full;
   assign rf_i2si_lvl  = wr_ptr - rd_ptr;

endmodule
